core_trap_unit: RTL and testbench

- Parametrised successor to the core's combinational trap handler.
- Adds the following:
  - NUM_INT synchronised interrupt lines, each configurable as level- or edge-triggered, with pending latches.
  - Fixed-priority interrupt arbitration.
  - A registered trap request held under a valid/ready handshake toward the CSR block.
- Sits between FETCH/EXEC/MEM exception sources, external interrupt pins, and the CSR trap-entry logic.

---
 rtl/core_trap_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_core_trap_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_trap_unit.sv
// ----------------------------------------------------------------------------
// core_pkg / core_trap_unit
//
// Purpose:
//   Collects synchronous exceptions from FETCH/EXEC/MEM and asynchronous
//   external interrupt lines, selects one trap, and presents it to the
//   CSR trap-entry logic as a registered request held under valid/ready.
//   Exceptions always take precedence over interrupts in the same cycle.
//
// Ports:
//   clk              core clock
//   rst_n            synchronous reset, active low
//   check_interrupt  controller permits interrupt acceptance this cycle
//   priv             current privilege level
//   cfg_mie          mstatus.MIE (only gates interrupts while in M-mode)
//   cfg_ie           per-line interrupt enable
//   int_src          raw asynchronous interrupt lines
//   ex_flags         exception flags, bit 9 = highest priority, bit 0 unused
//   pc_new           mtval for instruction-misaligned
//   imem_addr        mtval for instruction access fault
//   instr            mtval for illegal instruction
//   mem_addr         mtval for load/store faults and misaligns
//   trap_valid       trap request pending toward the CSR block
//   trap_ready       CSR block accepts the trap
//   trap_is_int      1 = interrupt, 0 = exception
//   trap_cause       exception code or interrupt code
//   trap_value       mtval
//   int_pending      current pending vector (mip view)
//   int_claim        one-hot pulse when an interrupt trap is accepted
// ----------------------------------------------------------------------------

package core_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    localparam logic [4:0] EX_INSTR_MISALIGNED   = 5'd0;
    localparam logic [4:0] EX_INSTR_ACCESS_FAULT = 5'd1;
    localparam logic [4:0] EX_ILLEGAL_INSTR      = 5'd2;
    localparam logic [4:0] EX_BREAKPOINT         = 5'd3;
    localparam logic [4:0] EX_LOAD_MISALIGNED    = 5'd4;
    localparam logic [4:0] EX_LOAD_ACCESS_FAULT  = 5'd5;
    localparam logic [4:0] EX_STORE_MISALIGNED   = 5'd6;
    localparam logic [4:0] EX_STORE_ACCESS_FAULT = 5'd7;
    localparam logic [4:0] EX_ECALL_UMODE        = 5'd8;
    localparam logic [4:0] EX_ECALL_SMODE        = 5'd9;
    localparam logic [4:0] EX_ECALL_MMODE        = 5'd11;

endpackage

// ----------------------------------------------------------------------------
// Trap FSM states
//   state | meaning
//   IDLE  | no request outstanding; exceptions/interrupts sampled for capture
//   HOLD  | trap_valid=1, trap_* frozen until trap_ready is seen
// ----------------------------------------------------------------------------
module core_trap_unit #(
    parameter int                 NUM_INT       = 4,
    parameter logic [NUM_INT-1:0] EDGE_MASK     = '0,
    parameter int                 SYNC_STAGES   = 2,
    parameter int                 INT_CODE_BASE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 check_interrupt,
    input  core_pkg::priv_e      priv,
    input  logic                 cfg_mie,
    input  logic [NUM_INT-1:0]   cfg_ie,
    input  logic [NUM_INT-1:0]   int_src,
    input  logic [9:0]           ex_flags,
    input  logic [31:0]          pc_new,
    input  logic [31:0]          imem_addr,
    input  logic [31:0]          instr,
    input  logic [31:0]          mem_addr,
    output logic                 trap_valid,
    input  logic                 trap_ready,
    output logic                 trap_is_int,
    output logic [4:0]           trap_cause,
    output logic [31:0]          trap_value,
    output logic [NUM_INT-1:0]   int_pending,
    output logic [NUM_INT-1:0]   int_claim
);

    import core_pkg::*;

    localparam int IDX_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
    localparam logic [NUM_INT-1:0] LINE0 = NUM_INT'(1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e state;

    // ------------------------------------------------------------------
    // Interrupt synchronisation and pending latches
    // ------------------------------------------------------------------
    logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
    logic [NUM_INT-1:0] s_cur;
    logic [NUM_INT-1:0] s_prev;
    logic [NUM_INT-1:0] rise;
    logic [NUM_INT-1:0] pend_edge_q;
    logic [NUM_INT-1:0] pend;

    assign s_cur = sync_q[SYNC_STAGES-1];
    assign rise  = s_cur & ~s_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            s_prev      <= '0;
            pend_edge_q <= '0;
        end else begin
            sync_q[0] <= int_src;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            s_prev <= s_cur;
            // Set is OR-ed after the clear so a new edge coinciding with
            // a claim keeps the line pending.
            pend_edge_q <= ((pend_edge_q & ~int_claim) | rise) & EDGE_MASK;
        end
    end

    // Level lines follow the synchronised input directly.
    assign pend        = (pend_edge_q & EDGE_MASK) | (s_cur & ~EDGE_MASK);
    assign int_pending = pend;

    // ------------------------------------------------------------------
    // Interrupt eligibility and fixed-priority arbitration
    // ------------------------------------------------------------------
    logic               ge;
    logic [NUM_INT-1:0] elig;
    logic               int_hit;
    logic [IDX_W-1:0]   int_win;

    assign ge   = (priv == PRIV_M) ? cfg_mie : 1'b1;
    assign elig = pend & cfg_ie & {NUM_INT{ge & check_interrupt}};

    // Scanning downward lets the lowest set index overwrite the others.
    always_comb begin
        int_hit = 1'b0;
        int_win = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (elig[i]) begin
                int_hit = 1'b1;
                int_win = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Exception priority decode and mtval selection
    // ------------------------------------------------------------------
    logic        exc_hit;
    logic [4:0]  exc_cause;
    logic [31:0] exc_value;
    logic        unused_ex0;

    assign exc_hit    = |ex_flags[9:1];
    assign unused_ex0 = ex_flags[0];

    always_comb begin
        exc_cause = EX_INSTR_MISALIGNED;
        exc_value = '0;
        if (ex_flags[9]) begin
            exc_cause = EX_INSTR_ACCESS_FAULT;
            exc_value = imem_addr;
        end else if (ex_flags[8]) begin
            exc_cause = EX_ILLEGAL_INSTR;
            exc_value = instr;
        end else if (ex_flags[7]) begin
            exc_cause = EX_INSTR_MISALIGNED;
            exc_value = pc_new;
        end else if (ex_flags[6]) begin
            case (priv)
                PRIV_M:  exc_cause = EX_ECALL_MMODE;
                PRIV_S:  exc_cause = EX_ECALL_SMODE;
                default: exc_cause = EX_ECALL_UMODE;
            endcase
        end else if (ex_flags[5]) begin
            exc_cause = EX_BREAKPOINT;
        end else if (ex_flags[4]) begin
            exc_cause = EX_LOAD_ACCESS_FAULT;
            exc_value = mem_addr;
        end else if (ex_flags[3]) begin
            exc_cause = EX_STORE_ACCESS_FAULT;
            exc_value = mem_addr;
        end else if (ex_flags[2]) begin
            exc_cause = EX_LOAD_MISALIGNED;
            exc_value = mem_addr;
        end else if (ex_flags[1]) begin
            exc_cause = EX_STORE_MISALIGNED;
            exc_value = mem_addr;
        end
    end

    // ------------------------------------------------------------------
    // Trap request FSM (registered outputs)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] int_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            trap_valid  <= 1'b0;
            trap_is_int <= 1'b0;
            trap_cause  <= '0;
            trap_value  <= '0;
            int_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc_hit) begin
                        state       <= HOLD;
                        trap_valid  <= 1'b1;
                        trap_is_int <= 1'b0;
                        trap_cause  <= exc_cause;
                        trap_value  <= exc_value;
                    end else if (int_hit) begin
                        state       <= HOLD;
                        trap_valid  <= 1'b1;
                        trap_is_int <= 1'b1;
                        trap_cause  <= 5'(INT_CODE_BASE) + 5'(int_win);
                        trap_value  <= '0;
                        int_idx     <= int_win;
                    end
                end
                HOLD: begin
                    if (trap_ready) begin
                        state      <= IDLE;
                        trap_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    trap_valid <= 1'b0;
                end
            endcase
        end
    end

    // Claim is a single-cycle pulse on the accepting handshake only.
    assign int_claim = (state == HOLD && trap_ready && trap_is_int) ?
                       (LINE0 << int_idx) : '0;

endmodule

// File: tb/tb_core_trap_unit.sv
// ----------------------------------------------------------------------------
// tb_core_trap_unit
//   Directed scenarios for reset, priority, masking, arbitration and the
//   edge set/clear collision, followed by randomized traps compared against
//   a behavioural model of the pending vector and the trap selection rules.
// ----------------------------------------------------------------------------
module tb_core_trap_unit;

    import core_pkg::*;

    localparam int         NI   = 4;
    localparam logic [3:0] EM   = 4'b0100;
    localparam int         SS   = 2;
    localparam int         BASE = 16;

    logic        clk;
    logic        rst_n;
    logic        check_interrupt;
    priv_e       priv;
    logic        cfg_mie;
    logic [3:0]  cfg_ie;
    logic [3:0]  int_src;
    logic [9:0]  ex_flags;
    logic [31:0] pc_new, imem_addr, instr, mem_addr;
    logic        trap_valid;
    logic        trap_ready;
    logic        trap_is_int;
    logic [4:0]  trap_cause;
    logic [31:0] trap_value;
    logic [3:0]  int_pending;
    logic [3:0]  int_claim;

    int errors = 0;
    int checks = 0;

    core_trap_unit #(
        .NUM_INT(NI), .EDGE_MASK(EM), .SYNC_STAGES(SS), .INT_CODE_BASE(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .check_interrupt(check_interrupt),
        .priv(priv), .cfg_mie(cfg_mie), .cfg_ie(cfg_ie), .int_src(int_src),
        .ex_flags(ex_flags), .pc_new(pc_new), .imem_addr(imem_addr),
        .instr(instr), .mem_addr(mem_addr), .trap_valid(trap_valid),
        .trap_ready(trap_ready), .trap_is_int(trap_is_int),
        .trap_cause(trap_cause), .trap_value(trap_value),
        .int_pending(int_pending), .int_claim(int_claim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    // Spec table: cause code for exception flag bit b.
    function automatic logic [4:0] ref_exc_cause(input int b, input priv_e p);
        case (b)
            9: return 5'd1;
            8: return 5'd2;
            7: return 5'd0;
            6: return (p == PRIV_M) ? 5'd11 : (p == PRIV_S) ? 5'd9 : 5'd8;
            5: return 5'd3;
            4: return 5'd5;
            3: return 5'd7;
            2: return 5'd4;
            default: return 5'd6;
        endcase
    endfunction

    function automatic logic [31:0] ref_exc_value(input int b);
        case (b)
            9: return imem_addr;
            8: return instr;
            7: return pc_new;
            6, 5: return 32'd0;
            default: return mem_addr;
        endcase
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; int_src = 4'hF; check_interrupt = 1'b0; priv = PRIV_U;
        cfg_mie = 1'b0; cfg_ie = 4'h0; ex_flags = '0; trap_ready = 1'b0;
        pc_new = '0; imem_addr = '0; instr = '0; mem_addr = '0;
        repeat (2) @(negedge clk);
        checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", trap_valid); end
        checks++; if (int_pending !== 4'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", int_pending); end
        checks++; if (int_claim !== 4'h0) begin errors++; $display("FAIL reset_claim got %h exp 0", int_claim); end
        int_src = 4'h0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (int_pending !== 4'h0 || trap_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset got pend=%h valid=%b exp 0/0", int_pending, trap_valid);
        end
    endtask

    task automatic test_exc_priority;
        priv = PRIV_U; check_interrupt = 1'b0; mem_addr = 32'h1234_5678;
        ex_flags = 10'b00_0100_0100;
        @(negedge clk);
        ex_flags = '0;
        checks++; if (trap_valid !== 1'b1 || trap_is_int !== 1'b0) begin
            errors++; $display("FAIL excprio_valid got v=%b int=%b exp 1/0", trap_valid, trap_is_int);
        end
        checks++; if (trap_cause !== 5'd8) begin errors++; $display("FAIL excprio_cause got %0d exp 8", trap_cause); end
        checks++; if (trap_value !== 32'd0) begin errors++; $display("FAIL excprio_value got %h exp 0", trap_value); end
        repeat (3) begin
            @(negedge clk);
            checks++; if (trap_valid !== 1'b1 || trap_cause !== 5'd8) begin
                errors++; $display("FAIL excprio_hold got v=%b c=%0d exp 1/8", trap_valid, trap_cause);
            end
        end
        trap_ready = 1'b1;
        #1;
        checks++; if (int_claim !== 4'h0) begin errors++; $display("FAIL excprio_claim got %h exp 0", int_claim); end
        @(negedge clk);
        trap_ready = 1'b0;
        checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL excprio_release got %b exp 0", trap_valid); end
    endtask

    task automatic test_exc_over_int;
        int_src = 4'b0010; cfg_ie = 4'hF; priv = PRIV_U; check_interrupt = 1'b0;
        repeat (3) @(negedge clk);
        check_interrupt = 1'b1; ex_flags = 10'b01_0000_0000; instr = 32'hDEADBEEF;
        @(negedge clk);
        ex_flags = '0;
        checks++; if (trap_valid !== 1'b1 || trap_is_int !== 1'b0 || trap_cause !== 5'd2) begin
            errors++; $display("FAIL excint_exc got v=%b int=%b c=%0d exp 1/0/2", trap_valid, trap_is_int, trap_cause);
        end
        checks++; if (trap_value !== 32'hDEADBEEF) begin errors++; $display("FAIL excint_value got %h exp deadbeef", trap_value); end
        trap_ready = 1'b1;
        @(negedge clk);
        trap_ready = 1'b0;
        checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL excint_gap got %b exp 0", trap_valid); end
        @(negedge clk);
        checks++; if (trap_valid !== 1'b1 || trap_is_int !== 1'b1 || trap_cause !== 5'd17 || trap_value !== 32'd0) begin
            errors++; $display("FAIL excint_int got v=%b int=%b c=%0d val=%h exp 1/1/17/0", trap_valid, trap_is_int, trap_cause, trap_value);
        end
        trap_ready = 1'b1; check_interrupt = 1'b0;
        #1;
        checks++; if (int_claim !== 4'b0010) begin errors++; $display("FAIL excint_claim got %b exp 0010", int_claim); end
        @(negedge clk);
        trap_ready = 1'b0; int_src = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_arbitration;
        int_src = 4'b1100; cfg_ie = 4'hF; priv = PRIV_U; check_interrupt = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (int_pending !== 4'b1100) begin errors++; $display("FAIL arb_pending got %b exp 1100", int_pending); end
        check_interrupt = 1'b1;
        @(negedge clk);
        checks++; if (trap_valid !== 1'b1 || trap_is_int !== 1'b1 || trap_cause !== 5'd18) begin
            errors++; $display("FAIL arb_first got v=%b int=%b c=%0d exp 1/1/18", trap_valid, trap_is_int, trap_cause);
        end
        trap_ready = 1'b1;
        #1;
        checks++; if (int_claim !== 4'b0100) begin errors++; $display("FAIL arb_claim2 got %b exp 0100", int_claim); end
        @(negedge clk);
        trap_ready = 1'b0;
        checks++; if (int_pending !== 4'b1000 || trap_valid !== 1'b0) begin
            errors++; $display("FAIL arb_clear got pend=%b v=%b exp 1000/0", int_pending, trap_valid);
        end
        @(negedge clk);
        checks++; if (trap_valid !== 1'b1 || trap_cause !== 5'd19) begin
            errors++; $display("FAIL arb_second got v=%b c=%0d exp 1/19", trap_valid, trap_cause);
        end
        trap_ready = 1'b1; check_interrupt = 1'b0;
        #1;
        checks++; if (int_claim !== 4'b1000) begin errors++; $display("FAIL arb_claim3 got %b exp 1000", int_claim); end
        @(negedge clk);
        trap_ready = 1'b0;
        checks++; if (int_pending !== 4'b1000 || trap_valid !== 1'b0) begin
            errors++; $display("FAIL arb_level_stays got pend=%b v=%b exp 1000/0", int_pending, trap_valid);
        end
        int_src = 4'h0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_masking;
        int_src = 4'b0001; priv = PRIV_M; cfg_mie = 1'b0; cfg_ie = 4'hF; check_interrupt = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (trap_valid !== 1'b0 || int_pending !== 4'b0001) begin
            errors++; $display("FAIL mask_mie0 got v=%b pend=%b exp 0/0001", trap_valid, int_pending);
        end
        cfg_mie = 1'b1;
        @(negedge clk);
        checks++; if (trap_valid !== 1'b1 || trap_cause !== 5'd16) begin
            errors++; $display("FAIL mask_mie1 got v=%b c=%0d exp 1/16", trap_valid, trap_cause);
        end
        trap_ready = 1'b1; check_interrupt = 1'b0;
        #1;
        checks++; if (int_claim !== 4'b0001) begin errors++; $display("FAIL mask_claim got %b exp 0001", int_claim); end
        @(negedge clk);
        trap_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL mask_check0 got %b exp 0", trap_valid); end
        check_interrupt = 1'b1;
        @(negedge clk);
        checks++; if (trap_valid !== 1'b1 || trap_cause !== 5'd16) begin
            errors++; $display("FAIL mask_check1 got v=%b c=%0d exp 1/16", trap_valid, trap_cause);
        end
        trap_ready = 1'b1; check_interrupt = 1'b0;
        @(negedge clk);
        trap_ready = 1'b0; int_src = 4'h0; cfg_mie = 1'b0; priv = PRIV_U;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_edge_collision;
        int_src = 4'b0100; cfg_ie = 4'hF; priv = PRIV_U; check_interrupt = 1'b0;
        repeat (4) @(negedge clk);
        check_interrupt = 1'b1;
        @(negedge clk);
        check_interrupt = 1'b0;
        checks++; if (trap_valid !== 1'b1 || trap_cause !== 5'd18) begin
            errors++; $display("FAIL coll_first got v=%b c=%0d exp 1/18", trap_valid, trap_cause);
        end
        int_src = 4'b0000;
        repeat (4) @(negedge clk);
        int_src = 4'b0100;
        repeat (2) @(negedge clk);
        // the new edge reaches the pending latch on the same edge as the claim
        trap_ready = 1'b1;
        #1;
        checks++; if (int_claim !== 4'b0100) begin errors++; $display("FAIL coll_claim got %b exp 0100", int_claim); end
        @(negedge clk);
        trap_ready = 1'b0;
        checks++; if (int_pending !== 4'b0100 || trap_valid !== 1'b0) begin
            errors++; $display("FAIL coll_pending got pend=%b v=%b exp 0100/0", int_pending, trap_valid);
        end
        check_interrupt = 1'b1;
        @(negedge clk);
        checks++; if (trap_valid !== 1'b1 || trap_cause !== 5'd18) begin
            errors++; $display("FAIL coll_second got v=%b c=%0d exp 1/18", trap_valid, trap_cause);
        end
        trap_ready = 1'b1; check_interrupt = 1'b0;
        @(negedge clk);
        trap_ready = 1'b0;
        checks++; if (int_pending !== 4'b0000) begin errors++; $display("FAIL coll_cleared got %b exp 0000", int_pending); end
        int_src = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_hold;
        int_src = 4'b0001; cfg_ie = 4'hF; priv = PRIV_U; check_interrupt = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (trap_valid !== 1'b1 || trap_cause !== 5'd16) begin
            errors++; $display("FAIL rsthold_pre got v=%b c=%0d exp 1/16", trap_valid, trap_cause);
        end
        check_interrupt = 1'b0; rst_n = 1'b0; trap_ready = 1'b1;
        @(negedge clk);
        checks++; if (trap_valid !== 1'b0 || int_claim !== 4'h0 || int_pending !== 4'h0) begin
            errors++; $display("FAIL rsthold_drop got v=%b claim=%b pend=%b exp 0/0/0", trap_valid, int_claim, int_pending);
        end
        rst_n = 1'b1; trap_ready = 1'b0; int_src = 4'h0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random;
        logic        pend2_m;
        logic [3:0]  lv, exp_pend, elig, exp_claim;
        logic        edge_new, ci, ge, exp_valid, exp_int;
        logic [4:0]  exp_cause;
        logic [31:0] exp_value;
        logic [9:0]  fl;
        int          sel;
        pend2_m = 1'b0;
        for (int it = 0; it < 40; it++) begin
            check_interrupt = 1'b0; ex_flags = '0;
            lv = 4'($urandom) & 4'b1011;
            edge_new = 1'($urandom_range(0, 1));
            if (edge_new) begin
                int_src = {lv[3], 1'b0, lv[1:0]};
                repeat (3) @(negedge clk);
                int_src[2] = 1'b1;
            end else begin
                int_src = {lv[3], int_src[2], lv[1:0]};
            end
            repeat (4) @(negedge clk);
            pend2_m  = pend2_m | edge_new;
            exp_pend = lv | {1'b0, pend2_m, 2'b00};
            checks++; if (int_pending !== exp_pend) begin
                errors++; $display("FAIL rnd_pending it=%0d got %b exp %b", it, int_pending, exp_pend);
            end

            cfg_ie  = 4'($urandom);
            cfg_mie = 1'($urandom_range(0, 1));
            sel     = $urandom_range(0, 2);
            priv    = (sel == 0) ? PRIV_U : (sel == 1) ? PRIV_S : PRIV_M;
            ci      = 1'($urandom_range(0, 1));
            fl      = ($urandom_range(0, 1) == 1) ? {9'($urandom), 1'b0} : 10'd0;
            pc_new = $urandom; imem_addr = $urandom; instr = $urandom; mem_addr = $urandom;
            check_interrupt = ci; ex_flags = fl;

            ge   = (priv == PRIV_M) ? cfg_mie : 1'b1;
            elig = exp_pend & cfg_ie & {4{ge & ci}};
            exp_valid = 1'b0; exp_int = 1'b0; exp_cause = '0; exp_value = '0; exp_claim = '0;
            for (int b = 9; b >= 1; b--) begin
                if (fl[b] && !exp_valid) begin
                    exp_valid = 1'b1;
                    exp_cause = ref_exc_cause(b, priv);
                    exp_value = ref_exc_value(b);
                end
            end
            if (!exp_valid) begin
                for (int i = 0; i < NI; i++) begin
                    if (elig[i] && !exp_valid) begin
                        exp_valid = 1'b1;
                        exp_int   = 1'b1;
                        exp_cause = 5'(BASE + i);
                        exp_claim = 4'(1 << i);
                    end
                end
            end

            @(negedge clk);
            ex_flags = '0; check_interrupt = 1'b0;
            checks++; if (trap_valid !== exp_valid) begin
                errors++; $display("FAIL rnd_valid it=%0d got %b exp %b", it, trap_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++; if (trap_is_int !== exp_int || trap_cause !== exp_cause || trap_value !== exp_value) begin
                    errors++; $display("FAIL rnd_trap it=%0d got int=%b c=%0d v=%h exp int=%b c=%0d v=%h",
                                       it, trap_is_int, trap_cause, trap_value, exp_int, exp_cause, exp_value);
                end
            end
            if (trap_valid === 1'b1) begin
                trap_ready = 1'b1;
                #1;
                if (exp_valid) begin
                    checks++; if (int_claim !== exp_claim) begin
                        errors++; $display("FAIL rnd_claim it=%0d got %b exp %b", it, int_claim, exp_claim);
                    end
                end
                @(negedge clk);
                trap_ready = 1'b0;
                if (exp_claim[2]) pend2_m = 1'b0;
                checks++; if (trap_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_release it=%0d got %b exp 0", it, trap_valid);
                end
            end
        end
        int_src = 4'h0; check_interrupt = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_exc_priority;
        test_exc_over_int;
        test_arbitration;
        test_masking;
        test_edge_collision;
        test_reset_mid_hold;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
